// File: rtl/brightness_oe_sequencer_pkg.sv
// Shared types and default parameters for the brightness OE sequencer.
// Timeout width is sized so BASE << (LEVELS-1) fits without wrap at the defaults.
package brightness_oe_sequencer_pkg;

  localparam int unsigned BRIGHTNESS_LEVELS                = 8;
  localparam int unsigned BRIGHTNESS_BASE_TIMEOUT          = 4;
  localparam int unsigned BRIGHTNESS_STATE_TIMEOUT_OVERLAP = 3;
  localparam int unsigned BRIGHTNESS_DEAD_TIME             = 2;
  localparam int unsigned BRIGHTNESS_DIM_WIDTH             = 8;
  localparam int unsigned BRIGHTNESS_TIMEOUT_WIDTH         = 10;

  typedef logic [BRIGHTNESS_LEVELS-1:0]        brightness_level_t;
  typedef logic [BRIGHTNESS_TIMEOUT_WIDTH-1:0] brightness_timeout_t;
  typedef logic [BRIGHTNESS_DIM_WIDTH-1:0]     brightness_dim_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    BLANK,
    ON,
    OFF
  } oe_state_t;

endpackage

// File: rtl/brightness_oe_sequencer_on_time_calc.sv
// Combinational window / on-time calculation for one bit-plane.
// Dimming arithmetic only exists when BRIGHTNESS_GLOBAL_DIM_EN is defined.
module brightness_on_time_calc
  import brightness_oe_sequencer_pkg::*;
#(
  parameter int unsigned LEVELS       = BRIGHTNESS_LEVELS,
  parameter int unsigned BASE_TIMEOUT = BRIGHTNESS_BASE_TIMEOUT,
  parameter int unsigned DIM_WIDTH    = BRIGHTNESS_DIM_WIDTH
) (
  input  brightness_level_t   mask,
  input  brightness_dim_t     global_dim,
  output brightness_timeout_t window,
  output brightness_timeout_t on_cycles,
  output logic                one_hot
);

  localparam int unsigned IDX_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int unsigned TW    = $bits(brightness_timeout_t);

  logic [IDX_W-1:0]    w_idx;
  brightness_timeout_t w_shifted;

  // Descending scan so the lowest set bit wins.
  always_comb begin
    w_idx = '0;
    for (int unsigned i = LEVELS; i > 0; i--) begin
      if (mask[IDX_W'(i - 1)]) w_idx = IDX_W'(i - 1);
    end
    one_hot   = $onehot(mask);
    w_shifted = brightness_timeout_t'(BASE_TIMEOUT << w_idx);
    if (!one_hot || (w_shifted == '0)) window = brightness_timeout_t'(1);
    else                               window = w_shifted;
  end

`ifdef BRIGHTNESS_GLOBAL_DIM_EN
  localparam int unsigned PW = TW + DIM_WIDTH + 1;

  logic [PW-1:0]       w_prod;
  brightness_timeout_t w_scaled;

  always_comb begin
    w_prod   = PW'(window) * (PW'(global_dim) + PW'(1));
    w_scaled = brightness_timeout_t'(w_prod >> DIM_WIDTH);
    if (w_scaled == '0)        on_cycles = brightness_timeout_t'(1);
    else if (w_scaled > window) on_cycles = window;
    else                        on_cycles = w_scaled;
  end
`else
  logic [DIM_WIDTH-1:0] w_unused_dim;

  assign w_unused_dim = global_dim;
  assign on_cycles    = window;
`endif

endmodule

// File: rtl/brightness_oe_sequencer.sv
// Per-plane OE sequencer: LOAD, optional BLANK dead time, ON for the dimmed
// fraction, OFF for the rest of the window. Dimming via BRIGHTNESS_GLOBAL_DIM_EN.
module brightness_oe_sequencer #(
  parameter int unsigned BRIGHTNESS_LEVELS                = brightness_oe_sequencer_pkg::BRIGHTNESS_LEVELS,
  parameter int unsigned BRIGHTNESS_BASE_TIMEOUT          = brightness_oe_sequencer_pkg::BRIGHTNESS_BASE_TIMEOUT,
  parameter int unsigned BRIGHTNESS_STATE_TIMEOUT_OVERLAP = brightness_oe_sequencer_pkg::BRIGHTNESS_STATE_TIMEOUT_OVERLAP,
  parameter int unsigned DEAD_TIME                        = brightness_oe_sequencer_pkg::BRIGHTNESS_DEAD_TIME,
  parameter int unsigned DIM_WIDTH                        = brightness_oe_sequencer_pkg::BRIGHTNESS_DIM_WIDTH
) (
  input  logic                                          clk_in,
  input  logic                                          reset,
  input  brightness_oe_sequencer_pkg::brightness_level_t brightness_mask_active,
  input  logic                                          row_latch,
  input  brightness_oe_sequencer_pkg::brightness_dim_t   global_dim,
  output logic                                          output_enable,
  output logic                                          exceeded_overlap_time,
  output logic                                          busy,
  output logic                                          plane_done,
  output logic                                          mask_error
);
  import brightness_oe_sequencer_pkg::*;

  localparam brightness_timeout_t T_ONE      = brightness_timeout_t'(1);
  localparam brightness_timeout_t T_OVERLAP  = brightness_timeout_t'(BRIGHTNESS_STATE_TIMEOUT_OVERLAP);
  localparam logic [7:0]          BLANK_LOAD = (DEAD_TIME > 0) ? 8'(DEAD_TIME - 1) : 8'd0;

  oe_state_t           r_state;
  logic                r_row_latch_q;
  brightness_timeout_t r_window;
  brightness_timeout_t r_on_cycles;
  brightness_timeout_t r_remaining;
  brightness_timeout_t r_on_left;
  logic [7:0]          r_blank_cnt;
  logic                r_oe;
  logic                r_exceeded;
  logic                r_busy;
  logic                r_done;
  logic                r_mask_error;

  logic                w_fall;
  brightness_timeout_t w_window;
  brightness_timeout_t w_on_cycles;
  logic                w_one_hot;

  assign w_fall = r_row_latch_q & ~row_latch;

  brightness_on_time_calc #(
    .LEVELS       (BRIGHTNESS_LEVELS),
    .BASE_TIMEOUT (BRIGHTNESS_BASE_TIMEOUT),
    .DIM_WIDTH    (DIM_WIDTH)
  ) u_calc (
    .mask       (brightness_mask_active),
    .global_dim (global_dim),
    .window     (w_window),
    .on_cycles  (w_on_cycles),
    .one_hot    (w_one_hot)
  );

  // r_oe lags the ON state by one cycle; on_left and remaining move in lockstep,
  // so on_left==1 with remaining==1 means the window had no OFF part.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_row_latch_q <= 1'b0;
      r_window      <= '0;
      r_on_cycles   <= '0;
      r_remaining   <= '0;
      r_on_left     <= '0;
      r_blank_cnt   <= '0;
      r_oe          <= 1'b0;
      r_exceeded    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_mask_error  <= 1'b0;
    end else begin
      r_row_latch_q <= row_latch;
      r_oe          <= 1'b0;
      r_done        <= 1'b0;
      r_exceeded    <= ~w_fall & (r_remaining > T_OVERLAP);
      if (w_fall) begin
        r_state     <= LOAD;
        r_remaining <= '0;
        r_on_left   <= '0;
        r_busy      <= 1'b1;
      end else begin
        unique case (r_state)
          IDLE: ;
          LOAD: begin
            r_window    <= w_window;
            r_on_cycles <= w_on_cycles;
            if (!w_one_hot) r_mask_error <= 1'b1;
            if (DEAD_TIME > 0) begin
              r_state     <= BLANK;
              r_blank_cnt <= BLANK_LOAD;
            end else begin
              r_state     <= ON;
              r_remaining <= w_window;
              r_on_left   <= w_on_cycles;
            end
          end
          BLANK: begin
            if (r_blank_cnt == 8'd0) begin
              r_state     <= ON;
              r_remaining <= r_window;
              r_on_left   <= r_on_cycles;
            end else begin
              r_blank_cnt <= r_blank_cnt - 8'd1;
            end
          end
          ON: begin
            r_oe        <= 1'b1;
            r_remaining <= r_remaining - T_ONE;
            r_on_left   <= r_on_left - T_ONE;
            if (r_on_left == T_ONE) begin
              if (r_remaining > T_ONE) begin
                r_state <= OFF;
              end else begin
                r_state <= IDLE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end
            end
          end
          OFF: begin
            r_remaining <= r_remaining - T_ONE;
            if (r_remaining == T_ONE) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Gate also on the registered latch so a stale ON cycle never leaks out
  // in the cycle where an aborting fall is being taken.
  assign output_enable         = r_oe & ~row_latch & ~r_row_latch_q;
  assign exceeded_overlap_time = r_exceeded;
  assign busy                  = r_busy;
  assign plane_done            = r_done;
  assign mask_error            = r_mask_error;

endmodule
